// File: rtl/fft16_sequencer.sv
// Purpose: sequences the shared radix-4 butterfly through a 16-point FFT (4 load passes, 4 column passes).
// Latency: first result word is valid 1 cycle after the 4th input word is accepted; then 1 word/clk.
// Backpressure: out_ready low holds out_data/out_idx stable; in_ready is low from CALC until the frame drains.
// Optional: define FFT16_FRAME_CNT_EN to add the frame_cnt[15:0] output (completed-frame counter).
module fft16_sequencer #(
    parameter int LANE_W = 34,
    parameter int LANES  = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic [LANES*LANE_W-1:0]   in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [LANES*LANE_W-1:0]   bf_in,
    output logic [2:0]                bf_rot,
    input  logic [LANES*LANE_W-1:0]   bf_out,
    output logic [LANES*LANE_W-1:0]   out_data,
    output logic [1:0]                out_idx,
    output logic                      out_valid,
    input  logic                      out_ready,
`ifdef FFT16_FRAME_CNT_EN
    output logic [15:0]               frame_cnt,
`endif
    output logic                      busy
);

    localparam int W = LANES * LANE_W;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_CALC  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    cnt_q, cnt_d;
    logic [W-1:0]  bank_q [LANES];
    logic [W-1:0]  bank_d [LANES];
    logic [W-1:0]  out_data_q, out_data_d;
    logic [1:0]    out_idx_q, out_idx_d;
    logic          out_valid_q, out_valid_d;
    logic [W-1:0]  col_word;
`ifdef FFT16_FRAME_CNT_EN
    logic [15:0]   frame_cnt_q, frame_cnt_d;
`endif

    // Transpose read: lane k of the column word is lane cnt of bank word k.
    always_comb begin
        col_word = '0;
        for (int k = 0; k < LANES; k++) begin
            col_word[k*LANE_W +: LANE_W] = bank_q[k][cnt_q*LANE_W +: LANE_W];
        end
    end

    // Next-state, datapath steering and handshake outputs.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bank_d      = bank_q;
        out_data_d  = out_data_q;
        out_idx_d   = out_idx_q;
        out_valid_d = out_valid_q;
`ifdef FFT16_FRAME_CNT_EN
        frame_cnt_d = frame_cnt_q;
`endif
        in_ready    = 1'b0;
        bf_in       = col_word;
        bf_rot      = {1'b1, cnt_q};

        case (state_q)
            ST_LOAD: begin
                in_ready = 1'b1;
                bf_in    = in_data;
                bf_rot   = {1'b0, cnt_q};
                if (in_valid) begin
                    bank_d[cnt_q] = bf_out;
                    cnt_d         = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_d = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                if (!out_valid_q || out_ready) begin
                    out_data_d  = bf_out;
                    out_idx_d   = cnt_q;
                    out_valid_d = 1'b1;
                    cnt_d       = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    cnt_d       = 2'd0;
                    state_d     = ST_LOAD;
`ifdef FFT16_FRAME_CNT_EN
                    frame_cnt_d = frame_cnt_q + 16'd1;
`endif
                end
            end
            default: begin
                state_d = ST_LOAD;
                cnt_d   = 2'd0;
            end
        endcase

        // Abort wins over everything, including an input beat this cycle; bank is left as is.
        if (flush) begin
            state_d     = ST_LOAD;
            cnt_d       = 2'd0;
            out_valid_d = 1'b0;
            bank_d      = bank_q;
`ifdef FFT16_FRAME_CNT_EN
            frame_cnt_d = frame_cnt_q;
`endif
        end
    end

    // State, counter, transpose bank and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_LOAD;
            cnt_q       <= 2'd0;
            for (int k = 0; k < LANES; k++) begin
                bank_q[k] <= '0;
            end
            out_data_q  <= '0;
            out_idx_q   <= 2'd0;
            out_valid_q <= 1'b0;
`ifdef FFT16_FRAME_CNT_EN
            frame_cnt_q <= 16'd0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            for (int k = 0; k < LANES; k++) begin
                bank_q[k] <= bank_d[k];
            end
            out_data_q  <= out_data_d;
            out_idx_q   <= out_idx_d;
            out_valid_q <= out_valid_d;
`ifdef FFT16_FRAME_CNT_EN
            frame_cnt_q <= frame_cnt_d;
`endif
        end
    end

    assign out_data  = out_data_q;
    assign out_idx   = out_idx_q;
    assign out_valid = out_valid_q;
    assign busy      = !((state_q == ST_LOAD) && (cnt_q == 2'd0));
`ifdef FFT16_FRAME_CNT_EN
    assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_fft16_sequencer.sv
// Bench for fft16_sequencer with an identity butterfly (bf_out = bf_in).
// Stimulus pushes expected result words; a negedge monitor pops and compares on each output handshake.
module tb_fft16_sequencer;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         flush;
    logic [135:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic [135:0] bf_in;
    logic [2:0]   bf_rot;
    logic [135:0] bf_out;
    logic [135:0] out_data;
    logic [1:0]   out_idx;
    logic         out_valid;
    logic         out_ready;
    logic         busy;
`ifdef FFT16_FRAME_CNT_EN
    logic [15:0]  frame_cnt;
`endif

    always #5 clk = ~clk;

    assign bf_out = bf_in;

    fft16_sequencer #(.LANE_W(34), .LANES(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bf_in     (bf_in),
        .bf_rot    (bf_rot),
        .bf_out    (bf_out),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef FFT16_FRAME_CNT_EN
        .frame_cnt (frame_cnt),
`endif
        .busy      (busy)
    );

    typedef struct packed {
        logic [1:0]   idx;
        logic [135:0] dat;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    exp_t held;
    logic held_v;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [135:0] act, input logic [135:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Lane value v: Re = v, Im = 0.
    function automatic logic [33:0] lane(input int v);
        logic [31:0] vv;
        vv = v;
        return {vv[16:0], 17'd0};
    endfunction

    function automatic logic [135:0] in_word(input int base, input int k);
        return {lane(base + 4*k + 3), lane(base + 4*k + 2), lane(base + 4*k + 1), lane(base + 4*k)};
    endfunction

    function automatic logic [135:0] out_word(input int base, input int p);
        return {lane(base + 12 + p), lane(base + 8 + p), lane(base + 4 + p), lane(base + p)};
    endfunction

    // Monitor: checks hold stability and pops the scoreboard on each handshake.
    always @(negedge clk) begin
        if (!rst_n) begin
            held_v <= 1'b0;
        end else begin
            if (held_v && out_valid) begin
                chk("hold_idx", out_idx, held.idx);
                chk("hold_data", out_data, held.dat);
            end
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_pop: output idx %0d with no expected word queued", out_idx);
                end else begin
                    mon_e = sb_q.pop_front();
                    chk("out_idx", out_idx, mon_e.idx);
                    chk("out_data", out_data, mon_e.dat);
                end
                held_v <= 1'b0;
            end else if (out_valid) begin
                held_v <= 1'b1;
                held   <= '{idx: out_idx, dat: out_data};
            end else begin
                held_v <= 1'b0;
            end
        end
    end

    task automatic send(input logic [135:0] w, input int rot);
        bit done;
        done     = 1'b0;
        in_data  = w;
        in_valid = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                done = 1'b1;
                chk("load_rot", bf_rot, rot);
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_data  = '0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready stayed 0 expected 1");
        end
    endtask

    task automatic send_frame(input int base, input bit gaps);
        for (int p = 0; p < 4; p++) begin
            sb_q.push_back('{idx: p[1:0], dat: out_word(base, p)});
        end
        for (int k = 0; k < 4; k++) begin
            send(in_word(base, k), k);
            if (gaps) begin
                in_data = {4{lane(999)}};
                @(negedge clk);
                chk("gap_in_ready", in_ready, (k < 3) ? 1'b1 : 1'b0);
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic wait_empty();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(posedge clk);
            #1;
            if (sb_q.size() == 0 && !out_valid) done = 1'b1;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL drain_timeout: %0d words left expected 0", sb_q.size());
        end
        chk("idle_in_ready", in_ready, 1'b1);
        chk("idle_busy", busy, 1'b0);
    endtask

    initial begin
        bit found;
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_data   = '0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_bf_rot", bf_rot, 3'd0);
        chk("rst_out_idx", out_idx, 2'd0);
        chk("rst_out_data", out_data, 136'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Scenario 1: basic frame, latency and rotation sequence.
        send_frame(0, 1'b0);
        @(negedge clk);
        chk("lat_valid0", out_valid, 1'b0);
        chk("calc_rot4", bf_rot, 3'd4);
        chk("calc_in_ready", in_ready, 1'b0);
        @(negedge clk);
        chk("lat_valid1", out_valid, 1'b1);
        chk("calc_rot5", bf_rot, 3'd5);
        @(negedge clk);
        chk("calc_rot6", bf_rot, 3'd6);
        @(negedge clk);
        chk("calc_rot7", bf_rot, 3'd7);
        wait_empty();

        // Scenario 2: stall the sink for 3 cycles on word 1.
        send_frame(100, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(posedge clk);
            #1;
            if (out_valid && out_idx == 2'd1) found = 1'b1;
        end
        chk("stall_found", found, 1'b1);
        out_ready = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("stall_in_ready", in_ready, 1'b0);
            chk("stall_idx", out_idx, 2'd1);
        end
        out_ready = 1'b1;
        wait_empty();

        // Scenario 3: idle cycles between input beats.
        send_frame(200, 1'b1);
        wait_empty();

        // Scenario 4: flush a partial frame, then a clean frame.
        send(in_word(300, 0), 0);
        send(in_word(300, 1), 1);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = in_word(300, 2);
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_in_ready", in_ready, 1'b1);
        chk("flush_busy", busy, 1'b0);
        chk("flush_rot", bf_rot, 3'd0);
        send_frame(400, 1'b0);
        wait_empty();

        // Scenario 5: asynchronous reset mid-CALC, then a full frame.
        out_ready = 1'b0;
        send_frame(500, 1'b0);
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 1'b0);
        chk("arst_in_ready", in_ready, 1'b1);
        chk("arst_busy", busy, 1'b0);
        sb_q.delete();
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        send_frame(600, 1'b0);
        wait_empty();
`ifdef FFT16_FRAME_CNT_EN
        chk("frame_cnt", frame_cnt, 16'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached expected completion");
        $fatal(1, "watchdog");
    end

endmodule
